crc_ccitt_frame_appender: RTL and testbench

//  Byte-stream TX stage for CRC-16/CCITT framing: passes each payload byte through
//  and appends the 2-byte CRC after the frame's last byte (high byte first).

---
 rtl/crc_ccitt_pkg.sv | 29 ++
 rtl/crc_ccitt_out_slot.sv | 55 +++++
 rtl/crc_ccitt_frame_appender.sv | 127 ++++++++++++
 tb/tb_crc_ccitt_frame_appender.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_ccitt_pkg.sv
// Shared definitions for the CRC-16/CCITT frame appender.
// Holds the generator polynomial, the framing FSM state type and the
// byte-parallel CRC update used by the top level.
package crc_ccitt_pkg;

  localparam logic [15:0] CRC_POLY = 16'h1021;

  typedef enum logic [1:0] {
    DATA   = 2'd0,
    CRC_HI = 2'd1,
    CRC_LO = 2'd2
  } state_t;

  // One byte of non-reflected, MSB-first CRC-16/CCITT; bit 7 of the byte enters first.
  function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc,
                                                   input logic [7:0]  data_byte);
    logic [15:0] c;
    c = crc ^ {data_byte, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) begin
        c = {c[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_ccitt_out_slot.sv
// Single-entry registered output slot for the frame appender.
// The slot accepts a new beat whenever it is empty or its current beat is
// being taken downstream (o_load_ok). While stalled, every output holds.
module crc_ccitt_out_slot
  import crc_ccitt_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_last,
  input  logic       i_crc_beat,
  input  logic       i_m_ready,
  output logic       o_load_ok,
  output logic       o_m_valid,
  output logic [7:0] o_m_data,
  output logic       o_m_last,
  output logic       o_crc_beat
);

  logic       r_valid;
  logic [7:0] r_data;
  logic       r_last;
  logic       r_crc_beat;
  logic       w_load_ok;

  assign w_load_ok  = !r_valid | i_m_ready;
  assign o_load_ok  = w_load_ok;
  assign o_m_valid  = r_valid;
  assign o_m_data   = r_data;
  assign o_m_last   = r_last;
  assign o_crc_beat = r_crc_beat;

  // Load a new beat, drain to empty, or hold the current beat under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_data     <= 8'h00;
      r_last     <= 1'b0;
      r_crc_beat <= 1'b0;
    end else if (w_load_ok) begin
      if (i_load) begin
        r_valid    <= 1'b1;
        r_data     <= i_data;
        r_last     <= i_last;
        r_crc_beat <= i_crc_beat;
      end else begin
        r_valid    <= 1'b0;
        r_last     <= 1'b0;
        r_crc_beat <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/crc_ccitt_frame_appender.sv
// CRC-16/CCITT frame appender: passes payload bytes through and appends the
// two CRC bytes (high first) after each frame's last byte, one byte per cycle.
// Build option: define CRC_FINAL_INVERT_EN to append ~crc instead of the raw
// register; the running CRC itself is the same in both builds.
module crc_ccitt_frame_appender
  import crc_ccitt_pkg::*;
#(
  parameter logic [15:0] INIT_VALUE = 16'hFFFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       crc_beat,
  output logic       frame_done
);

  state_t      r_state;
  logic [15:0] r_crc;
  logic        r_frame_done;

  logic        w_load_ok;
  logic        w_s_ready;
  logic        w_accept;
  logic [15:0] w_crc_out;
  logic        w_load;
  logic [7:0]  w_load_data;
  logic        w_load_last;
  logic        w_load_crc_beat;

`ifdef CRC_FINAL_INVERT_EN
  assign w_crc_out = ~r_crc;
`else
  assign w_crc_out = r_crc;
`endif

  assign w_s_ready  = (r_state == DATA) & w_load_ok & !reset;
  assign w_accept   = s_valid & w_s_ready;
  assign s_ready    = w_s_ready;
  assign frame_done = r_frame_done;

  // Select what the output slot loads this cycle: a payload byte or a CRC byte.
  always_comb begin
    w_load          = 1'b0;
    w_load_data     = 8'h00;
    w_load_last     = 1'b0;
    w_load_crc_beat = 1'b0;
    case (r_state)
      DATA: begin
        w_load      = w_accept;
        w_load_data = s_data;
      end
      CRC_HI: begin
        w_load          = w_load_ok;
        w_load_data     = w_crc_out[15:8];
        w_load_crc_beat = 1'b1;
      end
      CRC_LO: begin
        w_load          = w_load_ok;
        w_load_data     = w_crc_out[7:0];
        w_load_last     = 1'b1;
        w_load_crc_beat = 1'b1;
      end
      default: begin
        w_load = 1'b0;
      end
    endcase
  end

  // Framing FSM, running CRC and the frame_done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= DATA;
      r_crc        <= INIT_VALUE;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= m_valid & m_ready & m_last;
      case (r_state)
        DATA: begin
          if (w_accept) begin
            r_crc <= crc16_ccitt_byte(r_crc, s_data);
            if (s_last) begin
              r_state <= CRC_HI;
            end
          end
        end
        CRC_HI: begin
          if (w_load_ok) begin
            r_state <= CRC_LO;
          end
        end
        CRC_LO: begin
          if (w_load_ok) begin
            r_crc   <= INIT_VALUE;
            r_state <= DATA;
          end
        end
        default: begin
          r_state <= DATA;
          r_crc   <= INIT_VALUE;
        end
      endcase
    end
  end

  crc_ccitt_out_slot u_slot (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_data     (w_load_data),
    .i_last     (w_load_last),
    .i_crc_beat (w_load_crc_beat),
    .i_m_ready  (m_ready),
    .o_load_ok  (w_load_ok),
    .o_m_valid  (m_valid),
    .o_m_data   (m_data),
    .o_m_last   (m_last),
    .o_crc_beat (crc_beat)
  );

endmodule

// File: tb/tb_crc_ccitt_frame_appender.sv
// Self-checking bench for crc_ccitt_frame_appender.
// A bit-serial CRC model and an expected-beat queue predict every output beat;
// a negedge monitor checks the DUT against them every cycle.
module tb_crc_ccitt_frame_appender;

  localparam logic [15:0] INIT = 16'hFFFF;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       crc_beat;
  logic       frame_done;

  crc_ccitt_frame_appender #(.INIT_VALUE(INIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .crc_beat   (crc_beat),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       c;
  } beat_t;

  beat_t      q[$];
  logic [7:0] out_log[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         fd_count = 0;
  bit         rand_ready = 1'b0;
  logic [15:0] mcrc = INIT;

  // Bit-serial reference CRC: one polynomial step per message bit, MSB first.
  function automatic logic [15:0] mdl_crc(input logic [15:0] c, input logic [7:0] d);
    logic fb;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  function automatic logic [15:0] mdl_final(input logic [15:0] c);
`ifdef CRC_FINAL_INVERT_EN
    return ~c;
`else
    return c;
`endif
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready: always 1, or 50% random when enabled.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor and scoreboard: every negedge, check outputs, then account for the
  // handshakes that will occur at the coming posedge.
  initial begin
    bit         rst_seen = 1'b0;
    bit         prev_stall = 1'b0;
    bit         prev_in_hs = 1'b0;
    bit         prev_out_hs = 1'b0;
    bit         exp_fd = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;
    logic       prev_cb = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk(s_ready == 1'b0, "rst_s_ready", 32'(s_ready), 32'd0);
        q.delete();
        mcrc        = INIT;
        rst_seen    = 1'b1;
        prev_stall  = 1'b0;
        prev_in_hs  = 1'b0;
        prev_out_hs = 1'b0;
        exp_fd      = 1'b0;
      end else begin
        if (rst_seen) begin
          chk(m_valid == 1'b0,    "rst_m_valid",  32'(m_valid),    32'd0);
          chk(m_last == 1'b0,     "rst_m_last",   32'(m_last),     32'd0);
          chk(crc_beat == 1'b0,   "rst_crc_beat", 32'(crc_beat),   32'd0);
          chk(frame_done == 1'b0, "rst_fdone",    32'(frame_done), 32'd0);
          chk(m_data == 8'h00,    "rst_m_data",   32'(m_data),     32'd0);
          rst_seen = 1'b0;
        end
        chk(frame_done == exp_fd, "frame_done", 32'(frame_done), 32'(exp_fd));
        if (frame_done) fd_count++;
        if (prev_stall) begin
          chk(m_valid == 1'b1, "stall_valid", 32'(m_valid), 32'd1);
          chk({m_data, m_last, crc_beat} == {prev_data, prev_last, prev_cb},
              "stall_hold", 32'({m_data, m_last, crc_beat}), 32'({prev_data, prev_last, prev_cb}));
        end
        if (prev_in_hs) chk(m_valid == 1'b1, "latency", 32'(m_valid), 32'd1);
        if (prev_out_hs && q.size() > 0 && q[0].c)
          chk(m_valid == 1'b1, "crc_bubble", 32'(m_valid), 32'd1);
        if (m_valid) begin
          if (q.size() == 0) begin
            chk(1'b0, "unexpected_beat", 32'(m_data), 32'd0);
          end else begin
            chk({m_data, m_last, crc_beat} == {q[0].d, q[0].l, q[0].c}, "beat",
                32'({m_data, m_last, crc_beat}), 32'({q[0].d, q[0].l, q[0].c}));
          end
        end
        if (s_ready) begin
          bit bad = 1'b0;
          for (int i = 0; i < q.size(); i++)
            if (q[i].c && !(i == 0 && m_valid && m_ready)) bad = 1'b1;
          chk(!bad, "s_ready_in_crc", 32'(s_ready), 32'd0);
        end
        exp_fd = 1'b0;
        prev_out_hs = m_valid && m_ready;
        if (prev_out_hs && q.size() > 0) begin
          exp_fd = q[0].l;
          out_log.push_back(m_data);
          void'(q.pop_front());
        end
        prev_in_hs = s_valid && s_ready;
        if (prev_in_hs) begin
          logic [15:0] f;
          mcrc = mdl_crc(mcrc, s_data);
          q.push_back('{d: s_data, l: 1'b0, c: 1'b0});
          if (s_last) begin
            f = mdl_final(mcrc);
            q.push_back('{d: f[15:8], l: 1'b0, c: 1'b1});
            q.push_back('{d: f[7:0],  l: 1'b1, c: 1'b1});
            mcrc = INIT;
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        prev_cb    = crc_beat;
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input bit l);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk(1'b0, "send_timeout", 32'(n), 32'd200);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'($urandom_range(0, 1));
    s_data  = 8'($urandom);
  endtask

  task automatic send_123456789();
    for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i), i == 8);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((q.size() != 0 || m_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk(1'b0, "drain_timeout", 32'(q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_frame_bytes(input string name, input int base);
    logic [7:0] hi_exp;
    logic [7:0] lo_exp;
`ifdef CRC_FINAL_INVERT_EN
    hi_exp = 8'hD6;
    lo_exp = 8'h4E;
`else
    hi_exp = 8'h29;
    lo_exp = 8'hB1;
`endif
    for (int i = 0; i < 9; i++)
      chk(out_log[base + i] == 8'h31 + 8'(i), {name, "_payload"}, 32'(out_log[base + i]), 32'(8'h31 + 8'(i)));
    chk(out_log[base + 9] == hi_exp,  {name, "_crc_hi"}, 32'(out_log[base + 9]),  32'(hi_exp));
    chk(out_log[base + 10] == lo_exp, {name, "_crc_lo"}, 32'(out_log[base + 10]), 32'(lo_exp));
  endtask

  initial begin
    logic [15:0] c;
    logic [15:0] f;
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;

    // Pin the reference model with the catalogue check values.
    c = 16'hFFFF;
    for (int i = 0; i < 9; i++) c = mdl_crc(c, 8'h31 + 8'(i));
    chk(c == 16'h29B1, "model_ffff", 32'(c), 32'h29B1);
    c = 16'h0000;
    for (int i = 0; i < 9; i++) c = mdl_crc(c, 8'h31 + 8'(i));
    chk(c == 16'h31C3, "model_0000", 32'(c), 32'h31C3);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Test 1: reference frame with m_ready held high.
    out_log.delete();
    fd_count = 0;
    send_123456789();
    wait_idle();
    chk(out_log.size() == 11, "t1_count", 32'(out_log.size()), 32'd11);
    if (out_log.size() == 11) check_frame_bytes("t1", 0);
    chk(fd_count == 1, "t1_fdone_count", 32'(fd_count), 32'd1);

    // Test 2: same frame under random backpressure.
    rand_ready = 1'b1;
    out_log.delete();
    send_123456789();
    wait_idle();
    rand_ready = 1'b0;
    chk(out_log.size() == 11, "t2_count", 32'(out_log.size()), 32'd11);
    if (out_log.size() == 11) check_frame_bytes("t2", 0);

    // Test 3: two back-to-back frames.
    out_log.delete();
    send_123456789();
    send_123456789();
    wait_idle();
    chk(out_log.size() == 22, "t3_count", 32'(out_log.size()), 32'd22);
    if (out_log.size() == 22) begin
      check_frame_bytes("t3a", 0);
      check_frame_bytes("t3b", 11);
    end

    // Test 4: single-byte frame.
    out_log.delete();
    send_byte(8'h41, 1'b1);
    wait_idle();
    f = mdl_final(mdl_crc(INIT, 8'h41));
    chk(out_log.size() == 3, "t4_count", 32'(out_log.size()), 32'd3);
    if (out_log.size() == 3) begin
      chk(out_log[0] == 8'h41,    "t4_payload", 32'(out_log[0]), 32'h41);
      chk(out_log[1] == f[15:8],  "t4_crc_hi",  32'(out_log[1]), 32'(f[15:8]));
      chk(out_log[2] == f[7:0],   "t4_crc_lo",  32'(out_log[2]), 32'(f[7:0]));
    end

    // Test 5: reset in the middle of a frame, then a full frame.
    for (int i = 0; i < 4; i++) send_byte(8'h61 + 8'(i), 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    out_log.delete();
    send_123456789();
    wait_idle();
    chk(out_log.size() == 11, "t5_count", 32'(out_log.size()), 32'd11);
    if (out_log.size() == 11) check_frame_bytes("t5", 0);

    // Random frames, random gaps, random backpressure.
    rand_ready = 1'b1;
    for (int fr = 0; fr < 25; fr++) begin
      int len;
      len = $urandom_range(1, 7);
      for (int b = 0; b < len; b++) begin
        send_byte(8'($urandom), b == len - 1);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end
    wait_idle();
    rand_ready = 1'b0;
    chk(q.size() == 0, "final_drain", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the bench always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
